// File: rtl/detector_pkg.sv
// Shared types and constants for the serial pattern detector and its front end.
package detector_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  localparam int SER_WORDS_W = 16;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word holding buffer feeding a shift register that emits one bit per enabled cycle.
// Accept-to-first-bit latency is two edges; back-to-back words stream gaplessly; in_ready drops while the buffer is full.
module bit_serializer
  import detector_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enable,
  output logic                   x,
  output logic                   x_valid,
  output logic                   busy,
  output logic [SER_WORDS_W-1:0] words_sent
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             out_bit;

  // Gating with rst_n keeps the upstream from handing over a word that reset would discard.
  assign in_ready = !hold_valid && rst_n;
  assign accept   = in_valid && in_ready;
  assign out_bit  = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign x_valid  = (state == SER_SHIFT) && enable;
  assign x        = x_valid ? out_bit : IDLE_BIT;
  assign busy     = (state == SER_SHIFT) || hold_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SER_IDLE;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      sr         <= '0;
      cnt        <= '0;
      words_sent <= '0;
    end else begin
      // Accept never coincides with a reload: in_ready is low whenever hold_valid is set.
      if (accept) begin
        hold_data  <= in_data;
        hold_valid <= 1'b1;
      end

      case (state)
        SER_IDLE: begin
          if (hold_valid && enable) begin
            sr         <= hold_data;
            hold_valid <= 1'b0;
            cnt        <= '0;
            state      <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (enable) begin
            if (cnt == LAST_BIT) begin
              words_sent <= words_sent + 1'b1;
              cnt        <= '0;
              if (hold_valid) begin
                sr         <= hold_data;
                hold_valid <= 1'b0;
              end else begin
                sr    <= '0;
                state <= SER_IDLE;
              end
            end else begin
              sr  <= MSB_FIRST ? (sr << 1) : (sr >> 1);
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance for most scenarios, LSB-first instance for bit order.
module tb_bit_serializer;
  import detector_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   enable = 1'b1;
  logic                   x;
  logic                   x_valid;
  logic                   busy;
  logic [SER_WORDS_W-1:0] words_sent;

  logic [7:0]             l_in_data = '0;
  logic                   l_in_valid = 1'b0;
  logic                   l_in_ready;
  logic                   l_x;
  logic                   l_x_valid;
  logic                   l_busy;
  logic [SER_WORDS_W-1:0] l_words_sent;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .x(x), .x_valid(x_valid), .busy(busy), .words_sent(words_sent)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .enable(1'b1), .x(l_x), .x_valid(l_x_valid), .busy(l_busy), .words_sent(l_words_sent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0;
    in_valid = 1'b0;
    l_in_valid = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_bit(input string tag, input int i, input logic b);
    check($sformatf("%s_vld%0d", tag, i), x_valid, 1);
    check($sformatf("%s_bit%0d", tag, i), x, b);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]  w;
    logic [15:0] w16;
    int          ones;
    int          vlds;

    // Reset state
    tick();
    sample();
    check("rst_in_ready", in_ready, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_x", x, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    tick();
    rst_n = 1'b1;
    sample();
    check("rel_in_ready", in_ready, 1);

    // Single word, MSB first: D0 -> 1,1,0,1,0,0,0,0
    apply_reset();
    in_valid = 1'b1;
    in_data = 8'hD0;
    tick();
    in_valid = 1'b0;
    sample();
    check("single_in_ready_full", in_ready, 0);
    check("single_latency_vld", x_valid, 0);
    w = 8'b1101_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample();
      expect_bit("single", i, w[7-i]);
    end
    tick();
    sample();
    check("single_end_vld", x_valid, 0);
    check("single_end_x", x, 0);
    check("single_words", words_sent, 1);
    check("single_busy", busy, 0);

    // Back-to-back: A5 then 3C, 16 gapless bits
    apply_reset();
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_data = 8'h3C;
    sample();
    check("b2b_ready_after_acc", in_ready, 0);
    check("b2b_pre_vld", x_valid, 0);
    w16 = 16'b1010_0101_0011_1100;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      sample();
      expect_bit("b2b", i, w16[15-i]);
      if (i == 0) check("b2b_ready_reload1", in_ready, 1);
      if (i == 1) check("b2b_ready_acc2", in_ready, 0);
      if (i == 8) check("b2b_ready_reload2", in_ready, 1);
      if (i == 7) check("b2b_words_mid", words_sent, 0);
      if (i == 8) check("b2b_words_one", words_sent, 1);
    end
    tick();
    sample();
    check("b2b_end_vld", x_valid, 0);
    check("b2b_words", words_sent, 2);

    // Bit order, LSB first: 0B -> 1,1,0,1,0,0,0,0
    apply_reset();
    l_in_valid = 1'b1;
    l_in_data = 8'h0B;
    tick();
    l_in_valid = 1'b0;
    w = 8'b1101_0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample();
      check($sformatf("lsb_vld%0d", i), l_x_valid, 1);
      check($sformatf("lsb_bit%0d", i), l_x, w[7-i]);
    end
    tick();
    sample();
    check("lsb_end_vld", l_x_valid, 0);
    check("lsb_words", l_words_sent, 1);

    // Pause: enable low for 3 cycles after the 4th bit of FF
    apply_reset();
    in_valid = 1'b1;
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    ones = 0;
    vlds = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      enable = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
      sample();
      if (i >= 4 && i <= 6) begin
        check($sformatf("pause_vld%0d", i), x_valid, 0);
        check($sformatf("pause_x%0d", i), x, 0);
      end else begin
        expect_bit("pause", i, 1'b1);
      end
      ones += int'(x);
      vlds += int'(x_valid);
    end
    check("pause_words_last", words_sent, 0);
    tick();
    sample();
    check("pause_ones", ones, 8);
    check("pause_vld_count", vlds, 8);
    check("pause_end_vld", x_valid, 0);
    check("pause_words", words_sent, 1);

    // Reset during bit 5 with a second word buffered
    apply_reset();
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    sample();
    check("mid_busy_before", busy, 1);
    check("mid_bit4_vld", x_valid, 1);
    tick();
    rst_n = 1'b0;
    sample();
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    sample();
    check("mid_x_valid", x_valid, 0);
    check("mid_x", x, 0);
    check("mid_busy", busy, 0);
    check("mid_words", words_sent, 0);
    check("mid_in_ready", in_ready, 1);
    vlds = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sample();
      vlds += int'(x_valid);
    end
    check("mid_no_bits_after", vlds, 0);
    check("mid_busy_after", busy, 0);

    // Counter wrap from FFFF
    apply_reset();
    force dut.words_sent = 16'hFFFF;
    tick();
    release dut.words_sent;
    sample();
    check("wrap_preload", words_sent, 16'hFFFF);
    tick();
    in_valid = 1'b1;
    in_data = 8'h81;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    sample();
    check("wrap_end_vld", x_valid, 0);
    check("wrap_words", words_sent, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
